// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared RV32I pipeline definitions: ALUOp encodings, opcodes and the ID/EX control bundle.
package id_ex_pipe_reg_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    // A slot without a real instruction must never carry side-effecting control.
    function automatic id_ex_ctrl_t gate_ctrl(input id_ex_ctrl_t c);
        return c.valid ? c : '0;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID -> EX bundle: id_* driven by decode (master), ex_* driven by the pipeline register (slave).
interface id_ex_pipe_reg_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic              id_alu_src, id_branch, id_mem_to_reg;
    logic [1:0]        id_alu_op;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;

    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic              ex_alu_src, ex_branch, ex_mem_to_reg;
    logic [1:0]        ex_alu_op;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;

    modport master (
        output id_valid, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch,
               id_mem_to_reg, id_alu_op, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
        input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch,
               ex_mem_to_reg, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7
    );

    modport slave (
        input  id_valid, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch,
               id_mem_to_reg, id_alu_op, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
        output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch,
               ex_mem_to_reg, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7
    );
endinterface

// File: rtl/id_ex_pipe_reg_stage.sv
// Generic W-bit pipeline register: sync active-low reset > clear > hold > load.
module pipe_stage_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_hold,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold, flush and valid-bit bubble tracking.
// Define IDEX_BUBBLE_CNT_EN to add a saturating bubble_cnt output.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               flush,
`ifdef IDEX_BUBBLE_CNT_EN
    output logic [31:0]        bubble_cnt,
`endif
    id_ex_pipe_reg_if.slave    bus
);
    localparam int unsigned CtrlW = $bits(id_ex_ctrl_t);
    localparam int unsigned DataW = 4 * XLEN + 3 * REG_AW + 3 + 7;

    id_ex_ctrl_t      w_ctrl_raw, w_ctrl_d, w_ctrl_q;
    logic [CtrlW-1:0] w_ctrl_q_bits;
    logic [DataW-1:0] w_data_d, w_data_q;

    assign w_ctrl_raw = '{
        valid:      bus.id_valid,
        reg_write:  bus.id_reg_write,
        mem_read:   bus.id_mem_read,
        mem_write:  bus.id_mem_write,
        alu_src:    bus.id_alu_src,
        branch:     bus.id_branch,
        mem_to_reg: bus.id_mem_to_reg,
        alu_op:     bus.id_alu_op
    };
    assign w_ctrl_d = gate_ctrl(w_ctrl_raw);

    assign w_data_d = {bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
                       bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7};

    pipe_stage_reg #(.W(CtrlW)) u_ctrl_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (hold),
        .i_clear (flush),
        .i_d     (w_ctrl_d),
        .o_q     (w_ctrl_q_bits)
    );

    pipe_stage_reg #(.W(DataW)) u_data_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (hold),
        .i_clear (flush),
        .i_d     (w_data_d),
        .o_q     (w_data_q)
    );

    assign w_ctrl_q          = id_ex_ctrl_t'(w_ctrl_q_bits);
    assign bus.ex_valid      = w_ctrl_q.valid;
    assign bus.ex_reg_write  = w_ctrl_q.reg_write;
    assign bus.ex_mem_read   = w_ctrl_q.mem_read;
    assign bus.ex_mem_write  = w_ctrl_q.mem_write;
    assign bus.ex_alu_src    = w_ctrl_q.alu_src;
    assign bus.ex_branch     = w_ctrl_q.branch;
    assign bus.ex_mem_to_reg = w_ctrl_q.mem_to_reg;
    assign bus.ex_alu_op     = w_ctrl_q.alu_op;

    assign {bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
            bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7} = w_data_q;

`ifdef IDEX_BUBBLE_CNT_EN
    logic        w_bubble;
    logic [31:0] r_bubble_cnt;

    // Held slots are not new bubbles, even when the held slot is itself invalid.
    assign w_bubble = flush | (~hold & ~bus.id_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed vector table, then random traffic vs. a model.
module tb_id_ex_pipe_reg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic        valid, reg_write, mem_read, mem_write, alu_src, branch, mem_to_reg;
        logic [1:0]  alu_op;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } bundle_t;

    typedef struct {
        string       name;
        logic        rst_n, hold, flush;
        bundle_t     in;
        bundle_t     exp;
        logic [31:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, hold, flush;
    logic [31:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    bundle_t cur;
    longint  m_cnt;
    vec_t    vecs[9];

    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

`ifdef IDEX_BUBBLE_CNT_EN
    id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .flush      (flush),
        .bubble_cnt (bubble_cnt),
        .bus        (bus.slave)
    );
`else
    assign bubble_cnt = 32'd0;
    id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .flush (flush),
        .bus   (bus.slave)
    );
`endif

    function automatic bundle_t rnd_bundle();
        bundle_t b;
        b.valid = ($urandom_range(0, 3) != 0);
        b.reg_write = 1'($urandom); b.mem_read = 1'($urandom); b.mem_write = 1'($urandom);
        b.alu_src = 1'($urandom); b.branch = 1'($urandom); b.mem_to_reg = 1'($urandom);
        b.alu_op = 2'($urandom);
        b.pc = $urandom; b.rs1_data = $urandom; b.rs2_data = $urandom; b.imm = $urandom;
        b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.rd = 5'($urandom);
        b.funct3 = 3'($urandom); b.funct7 = 7'($urandom);
        return b;
    endfunction

    function automatic bundle_t zero_ctrl(input bundle_t b);
        bundle_t r = b;
        r.valid = 0; r.reg_write = 0; r.mem_read = 0; r.mem_write = 0;
        r.alu_src = 0; r.branch = 0; r.mem_to_reg = 0; r.alu_op = 2'b00;
        return r;
    endfunction

    // Reference: reset and flush yield an all-zero slot, hold keeps it, an invalid load is a bubble.
    function automatic bundle_t model_next(input logic rn, input logic h, input logic f,
                                           input bundle_t in, input bundle_t c);
        if (!rn || f) return '0;
        if (h) return c;
        return in.valid ? in : zero_ctrl(in);
    endfunction

    function automatic longint model_cnt(input logic rn, input logic h, input logic f,
                                         input bundle_t in, input longint c);
        if (!rn) return 0;
        if ((f || (!h && !in.valid)) && c < 64'hFFFF_FFFF) return c + 1;
        return c;
    endfunction

    task automatic drive(input logic rn, input logic h, input logic f, input bundle_t b);
        rst_n = rn; hold = h; flush = f;
        bus.id_valid = b.valid; bus.id_reg_write = b.reg_write; bus.id_mem_read = b.mem_read;
        bus.id_mem_write = b.mem_write; bus.id_alu_src = b.alu_src; bus.id_branch = b.branch;
        bus.id_mem_to_reg = b.mem_to_reg; bus.id_alu_op = b.alu_op; bus.id_pc = b.pc;
        bus.id_rs1_data = b.rs1_data; bus.id_rs2_data = b.rs2_data; bus.id_imm = b.imm;
        bus.id_rs1 = b.rs1; bus.id_rs2 = b.rs2; bus.id_rd = b.rd;
        bus.id_funct3 = b.funct3; bus.id_funct7 = b.funct7;
    endtask

    function automatic bundle_t sample();
        bundle_t b;
        b.valid = bus.ex_valid; b.reg_write = bus.ex_reg_write; b.mem_read = bus.ex_mem_read;
        b.mem_write = bus.ex_mem_write; b.alu_src = bus.ex_alu_src; b.branch = bus.ex_branch;
        b.mem_to_reg = bus.ex_mem_to_reg; b.alu_op = bus.ex_alu_op; b.pc = bus.ex_pc;
        b.rs1_data = bus.ex_rs1_data; b.rs2_data = bus.ex_rs2_data; b.imm = bus.ex_imm;
        b.rs1 = bus.ex_rs1; b.rs2 = bus.ex_rs2; b.rd = bus.ex_rd;
        b.funct3 = bus.ex_funct3; b.funct7 = bus.ex_funct7;
        return b;
    endfunction

    task automatic check_ex(input string name, input bundle_t exp);
        bundle_t got = sample();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: ex got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [31:0] exp);
`ifdef IDEX_BUBBLE_CNT_EN
        n_checks++;
        if (bubble_cnt !== exp) begin
            n_errors++;
            $display("FAIL %s: bubble_cnt got=%h required=%h", name, bubble_cnt, exp);
        end
`endif
    endtask

    initial begin
        bundle_t b, lw, nxt;
        logic rn, h, f;

        // Directed table
        vecs[0].name = "reset";     vecs[0].rst_n = 0; vecs[0].hold = 1; vecs[0].flush = 1;
        vecs[0].in = '1; vecs[0].exp = '0; vecs[0].exp_cnt = 0;

        b = rnd_bundle(); b.valid = 1; b.reg_write = 1; b.alu_op = 2'b10;
        b.rs1_data = 32'h0000_0005; b.rd = 5'd7;
        vecs[1].name = "load_rtype"; vecs[1].rst_n = 1; vecs[1].hold = 0; vecs[1].flush = 0;
        vecs[1].in = b; vecs[1].exp = b; vecs[1].exp_cnt = 0;

        for (int i = 2; i <= 4; i++) begin
            vecs[i].name = $sformatf("hold%0d", i - 1);
            vecs[i].rst_n = 1; vecs[i].hold = 1; vecs[i].flush = 0;
            vecs[i].in = rnd_bundle(); vecs[i].in.valid = 1;
            vecs[i].exp = b; vecs[i].exp_cnt = 0;
        end

        vecs[5].name = "release";   vecs[5].rst_n = 1; vecs[5].hold = 0; vecs[5].flush = 0;
        vecs[5].in = vecs[4].in; vecs[5].exp = vecs[4].in; vecs[5].exp_cnt = 0;

        lw = rnd_bundle(); lw.valid = 1; lw.reg_write = 1; lw.mem_read = 1; lw.mem_write = 0;
        lw.alu_src = 1; lw.branch = 0; lw.mem_to_reg = 1; lw.alu_op = 2'b00; lw.rd = 5'd9;
        vecs[6].name = "load_lw";   vecs[6].rst_n = 1; vecs[6].hold = 0; vecs[6].flush = 0;
        vecs[6].in = lw; vecs[6].exp = lw; vecs[6].exp_cnt = 0;

        vecs[7].name = "hold_flush"; vecs[7].rst_n = 1; vecs[7].hold = 1; vecs[7].flush = 1;
        vecs[7].in = rnd_bundle(); vecs[7].exp = '0; vecs[7].exp_cnt = 1;

        b = rnd_bundle(); b.valid = 0; b.mem_write = 1; b.reg_write = 1; b.branch = 1;
        vecs[8].name = "invalid_load"; vecs[8].rst_n = 1; vecs[8].hold = 0; vecs[8].flush = 0;
        vecs[8].in = b; vecs[8].exp = zero_ctrl(b); vecs[8].exp_cnt = 2;

        drive(1'b0, 1'b0, 1'b0, '0);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].hold, vecs[i].flush, vecs[i].in);
            @(posedge clk); #1;
            check_ex(vecs[i].name, vecs[i].exp);
            check_cnt(vecs[i].name, vecs[i].exp_cnt);
        end
        cur = vecs[8].exp;
        m_cnt = 2;

        // Random traffic; also confirm inputs never reach outputs before the edge
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rn = ($urandom_range(0, 39) != 0);
            h = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            b = rnd_bundle();
            drive(rn, h, f, b);
            #1;
            check_ex("no_comb_path", cur);
            nxt = model_next(rn, h, f, b, cur);
            m_cnt = model_cnt(rn, h, f, b, m_cnt);
            @(posedge clk); #1;
            cur = nxt;
            check_ex("random", cur);
            check_cnt("random_cnt", m_cnt[31:0]);
        end

`ifdef IDEX_BUBBLE_CNT_EN
        // Saturation: preload near the top, then three flushes
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, rnd_bundle());
        force dut.r_bubble_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_bubble_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b1, rnd_bundle());
            @(posedge clk); #1;
            check_ex("sat_flush", '0);
            check_cnt($sformatf("saturate%0d", k), (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
